// File: rtl/multimode_counter.sv
// multimode_counter
//   Up/down counter bounded to 0..MAX_VAL with synchronous load and a
//   registered terminal-count flag. At a bound the counter either wraps
//   (SATURATE=0, so it behaves as a modulo-(MAX_VAL+1) counter) or holds
//   (SATURATE=1).
//
// Parameters
//   WIDTH    : counter width in bits, 2..32
//   MAX_VAL  : upper count bound, 1..2**WIDTH-1
//   SATURATE : 0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports
//   clk      : clock; all state changes on its rising edge
//   rst      : synchronous active-high reset; counter and tc go to 0
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous load strobe; takes priority over en
//   load_val : value to load; it is clamped to MAX_VAL
//   counter  : registered count value
//   tc       : registered flag; high for the cycle after a boundary step
module multimode_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc
);

    // Reject parameter sets that cannot describe a valid counter.
    if (WIDTH < 2 || WIDTH > 32 || MAX_VAL == 64'd0 ||
        MAX_VAL > ((64'd1 << WIDTH) - 64'd1) ||
        (SATURATE != 0 && SATURATE != 1)) begin : g_param_err
        $error("multimode_counter: illegal parameters WIDTH=%0d MAX_VAL=%0d SATURATE=%0d",
               WIDTH, MAX_VAL, SATURATE);
    end

    localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];
    localparam bit               SAT  = (SATURATE == 1);

    logic [WIDTH-1:0] load_clamped;
    logic             at_top;
    logic             at_bot;

    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;
    assign at_top       = (counter == MAXV);
    assign at_bot       = (counter == '0);

    // An X on en is treated like en=0 here: the if falls to the hold path.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            tc      <= 1'b0;
        end else if (load) begin
            counter <= load_clamped;
            tc      <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    counter <= SAT ? MAXV : '0;
                    tc      <= 1'b1;
                end else begin
                    counter <= counter + WIDTH'(1);
                    tc      <= 1'b0;
                end
            end else begin
                if (at_bot) begin
                    counter <= SAT ? '0 : MAXV;
                    tc      <= 1'b1;
                end else begin
                    counter <= counter - WIDTH'(1);
                    tc      <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter. Three instances share one stimulus stream:
//   d0: WIDTH=4, MAX_VAL=15, wrap
//   d1: WIDTH=4, MAX_VAL=9,  wrap
//   d2: WIDTH=4, MAX_VAL=15, saturate
// A directed vector table covers the boundary scenarios; afterwards random
// stimulus is compared against an arithmetic reference model.
module tb_multimode_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] load_val;
    logic [3:0] c0, c1, c2;
    logic       t0, t1, t2;

    always #5 clk = ~clk;

    multimode_counter #(.WIDTH(4)) d0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .counter(c0), .tc(t0));
    multimode_counter #(.WIDTH(4), .MAX_VAL(9)) d1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .counter(c1), .tc(t1));
    multimode_counter #(.WIDTH(4), .SATURATE(1)) d2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .counter(c2), .tc(t2));

    typedef struct {
        int sel;
        bit r, ld, e, u;
        int lv;
        int ec;
        int et;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state per instance.
    int mc[3];
    int mt[3];
    int mmax[3] = '{15, 9, 15};
    int msat[3] = '{0, 0, 1};

    // Next count from the rules: reset, then clamped load, then +/-1
    // with a boundary step when the result leaves 0..max.
    function automatic int model_next(input int c, input int mx, input int sat,
                                      input bit r, input bit ld, input int lv,
                                      input bit e, input bit u, output int t);
        int n;
        t = 0;
        if (r) return 0;
        if (ld) return (lv > mx) ? mx : lv;
        if (!e) return c;
        n = u ? c + 1 : c - 1;
        if (n > mx || n < 0) begin
            t = 1;
            if (sat != 0) return c;
            return (n > mx) ? 0 : mx;
        end
        return n;
    endfunction

    task automatic add(input int sel, input bit r, input bit ld, input bit e,
                       input bit u, input int lv, input int ec, input int et);
        vec_t v;
        v.sel = sel; v.r = r; v.ld = ld; v.e = e; v.u = u;
        v.lv = lv; v.ec = ec; v.et = et;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one edge's worth of inputs and advance the model alongside.
    task automatic apply(input bit r, input bit ld, input bit e, input bit u,
                         input int lv);
        int t;
        rst = r; load = ld; en = e; up = u; load_val = 4'(lv);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            mc[k] = model_next(mc[k], mmax[k], msat[k], r, ld, lv, e, u, t);
            mt[k] = t;
        end
        #1;
    endtask

    function automatic int act_cnt(input int sel);
        case (sel)
            0:       return int'(c0);
            1:       return int'(c1);
            default: return int'(c2);
        endcase
    endfunction

    function automatic int act_tc(input int sel);
        case (sel)
            0:       return int'(t0);
            1:       return int'(t1);
            default: return int'(t2);
        endcase
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
        for (int k = 0; k < 3; k++) begin mc[k] = 0; mt[k] = 0; end

        // Wrap-up over the full range on d0.
        add(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 15; i++) add(0, 0, 0, 1, 1, 0, i, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 1, 0);

        // Count down from reset on d1 (MAX_VAL=9).
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 9, 1);
        for (int i = 8; i >= 0; i--) add(1, 0, 0, 1, 0, 0, i, 0);
        add(1, 0, 0, 1, 0, 0, 9, 1);

        // Modulo wrap below 2**WIDTH-1 on d1.
        add(1, 0, 0, 1, 1, 0, 0, 1);
        add(1, 0, 0, 1, 1, 0, 1, 0);

        // Saturation at the top on d2, then direction change.
        add(2, 0, 1, 0, 1, 14, 14, 0);
        add(2, 0, 0, 1, 1, 0, 15, 0);
        add(2, 0, 0, 1, 1, 0, 15, 1);
        add(2, 0, 0, 1, 1, 0, 15, 1);
        add(2, 0, 0, 1, 0, 0, 14, 0);
        // Saturation at the bottom on d2, then tc clears when idle.
        add(2, 0, 1, 1, 1, 0, 0, 0);
        add(2, 0, 0, 1, 0, 0, 0, 1);
        add(2, 0, 0, 1, 0, 0, 0, 1);
        add(2, 0, 0, 0, 0, 0, 0, 0);

        // Load clamps to MAX_VAL and beats en; reset beats load.
        add(1, 0, 1, 1, 1, 12, 9, 0);
        add(1, 1, 1, 1, 1, 5, 0, 0);

        // Reset mid-count, then resume from 0.
        add(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) add(0, 0, 0, 1, 1, 0, i, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 1, 1, 0, i, 0);

        // Hold at 7 with en=0 while up toggles.
        add(0, 0, 1, 0, 1, 7, 7, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, i % 2, 0, 7, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].lv);
            check($sformatf("vec%0d_d%0d_counter", i, tbl[i].sel),
                  act_cnt(tbl[i].sel), tbl[i].ec);
            check($sformatf("vec%0d_d%0d_tc", i, tbl[i].sel),
                  act_tc(tbl[i].sel), tbl[i].et);
        end

        // Random phase. Direction changes rarely so the bounds get hit.
        begin
            bit u_r = 1'b1;
            for (int n = 0; n < 600; n++) begin
                bit r_r, ld_r, e_r;
                int lv_r;
                if ($urandom_range(0, 7) == 0) u_r = ~u_r;
                r_r  = ($urandom_range(0, 59) == 0);
                ld_r = ($urandom_range(0, 14) == 0);
                e_r  = ($urandom_range(0, 4) != 0);
                lv_r = int'($urandom_range(0, 15));
                apply(r_r, ld_r, e_r, u_r, lv_r);
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("rnd%0d_d%0d_counter", n, k), act_cnt(k), mc[k]);
                    check($sformatf("rnd%0d_d%0d_tc", n, k), act_tc(k), mt[k]);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multimode_counter.md
MULTIMODE_COUNTER -- requirements
Module: multimode_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 The module SHALL have parameter MAX_VAL, default 2**WIDTH-1: upper count bound, legal range 1..2**WIDTH-1.
REQ-003 The module SHALL have parameter SATURATE, default 0: 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port en, input, 1 bit: count enable.
REQ-007 The module SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-008 The module SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 The module SHALL have port load_val, input, WIDTH bits: value to load.
REQ-010 The module SHALL have port counter, output, WIDTH bits: registered count value.
REQ-011 The module SHALL have port tc, output, 1 bit: registered terminal-count flag.

Function
REQ-012 The module SHALL update counter and tc only on rising clk edges; both outputs SHALL be driven directly from flops.
REQ-013 Per-edge priority SHALL be: rst, then load, then en; with none of these asserted, counter SHALL hold and tc SHALL be 0.
REQ-014 On load, counter SHALL become min(load_val, MAX_VAL) regardless of en and up, and tc SHALL be 0 on the next cycle.
REQ-015 With en=1, up=1 and counter<MAX_VAL, counter SHALL become counter+1 on the next edge and tc SHALL be 0.
REQ-016 With en=1, up=0 and counter>0, counter SHALL become counter-1 on the next edge and tc SHALL be 0.
REQ-017 With en=1, up=1 and counter==MAX_VAL, counter SHALL become 0 when SATURATE=0, or hold at MAX_VAL when SATURATE=1.
REQ-018 With en=1, up=0 and counter==0, counter SHALL become MAX_VAL when SATURATE=0, or hold at 0 when SATURATE=1.
REQ-019 tc SHALL be 1 for the cycle following each edge at which a REQ-017/REQ-018 boundary step occurred; in saturate mode it SHALL stay 1 on every consecutive enabled cycle at the bound.
REQ-020 A direction change SHALL take effect on the same edge that up is sampled, with no idle or extra cycle.
REQ-021 Counter arithmetic SHALL be performed at WIDTH bits; counter SHALL never exceed MAX_VAL, including after a load.
REQ-022 With MAX_VAL < 2**WIDTH-1, counting up SHALL wrap at MAX_VAL, not at 2**WIDTH-1 (modulo-(MAX_VAL+1) counter).
REQ-023 An illegal parameter combination (MAX_VAL=0, MAX_VAL>2**WIDTH-1, or SATURATE not 0 or 1) SHALL raise an elaboration-time error in simulation.
REQ-024 While rst=0 and load=0, an X on en SHALL cause no update beyond what en=0 gives, and counter SHALL hold; the bench SHALL check this by driving en=0 explicitly.

Reset
REQ-025 On a rising clk edge with rst=1, counter SHALL become 0 and tc SHALL become 0, overriding load and en.
REQ-026 Reset asserted mid-count SHALL take effect on the next edge; counting SHALL resume from 0 on the first edge after rst deasserts, with no extra latency.
REQ-027 Until the first reset edge, output values SHALL be unspecified; the bench SHALL assert rst for at least one edge.

Verification
REQ-028 WIDTH=4, default MAX_VAL, SATURATE=0: rst 1 cycle, then en=1, up=1 for 17 cycles -> counter 0,1,...,15,0; tc=1 only in the cycle counter reads 0 after 15.
REQ-029 WIDTH=4, MAX_VAL=9, SATURATE=0: en=1, up=0 from reset -> counter 9,8,...,0,9; tc=1 in the cycle after the 0->9 step.
REQ-030 WIDTH=4, SATURATE=1: load=1, load_val=14, then up=1 for 4 cycles -> counter 14,15,15,15; tc=0,1,1 over the last three cycles; then up=0 -> counter 14 and tc=0.
REQ-031 WIDTH=4, MAX_VAL=9: load_val=12 with load=1 and en=1 on the same edge -> counter=9 and tc=0; simultaneous rst=1 and load=1 -> counter=0.
REQ-032 Count to 6, assert rst for one edge with en=1 -> counter=0 next cycle; deassert rst -> counter 1,2,3 on the following edges.
REQ-033 en=0 for 5 cycles at counter=7 -> counter stays 7 and tc=0 throughout; toggling up while en=0 -> no change.
